// File: rtl/key_zone_detector.sv
// Per-zone bright-pixel counters over a vertical window; at frame end each zone
// is evaluated against hysteresis thresholds and a pressed-key bitmap is published.
module key_zone_counter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;

  // Clear wins over increment; increment saturates instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)                       cnt_q <= '0;
    else if (clr_i)                    cnt_q <= '0;
    else if (inc_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
endmodule

module key_zone_detector #(
  parameter int NUM_KEYS       = 8,
  parameter int KEY_WIDTH_LOG2 = 6,
  parameter int H_START        = 64,
  parameter int V_START        = 200,
  parameter int V_END          = 479,
  parameter int FRAME_LAST_H   = 1023,
  parameter int FRAME_LAST_V   = 767,
  parameter int THRESH_ON      = 400,
  parameter int THRESH_OFF     = 200
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                data_valid_in,
  input  logic                pixel_data_in,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic                keys_valid_out,
  output logic                keys_changed_out
);
  localparam int          KIW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [31:0] H_LO  = 32'(H_START);
  localparam logic [31:0] H_HI  = 32'(H_START + (NUM_KEYS << KEY_WIDTH_LOG2));
  localparam logic [31:0] V_LO  = 32'(V_START);
  localparam logic [31:0] V_HI  = 32'(V_END);
  localparam logic [10:0] FL_H  = 11'(FRAME_LAST_H);
  localparam logic [9:0]  FL_V  = 10'(FRAME_LAST_V);
  localparam logic [15:0] T_ON  = 16'(THRESH_ON);
  localparam logic [15:0] T_OFF = 16'(THRESH_OFF);

  typedef enum logic {ACCUM, EVAL} state_e;

  state_e                      state_q;
  logic [KIW-1:0]              k_q;
  logic [NUM_KEYS-1:0]         nxt_q, nxt_d;
  logic [NUM_KEYS-1:0]         keys_q;
  logic                        vld_q, chg_q;
  logic [NUM_KEYS-1:0][15:0]   cnt_w;

  logic [31:0]    h32, v32, h_off;
  logic           in_win, count_en, frame_end, last_k, cur_bit;
  logic [KIW-1:0] zone;
  logic [15:0]    cur;

  assign h32       = 32'(hcount_in);
  assign v32       = 32'(vcount_in);
  assign in_win    = data_valid_in && v32 >= V_LO && v32 <= V_HI && h32 >= H_LO && h32 < H_HI;
  assign h_off     = h32 - H_LO;
  assign zone      = KIW'(h_off >> KEY_WIDTH_LOG2);
  assign count_en  = (state_q == ACCUM) && in_win && pixel_data_in;
  assign frame_end = (state_q == ACCUM) && data_valid_in && hcount_in == FL_H && vcount_in == FL_V;
  assign last_k    = (k_q == KIW'(NUM_KEYS - 1));

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_zone
    key_zone_counter u_cnt (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr_i  (state_q == EVAL && k_q == KIW'(g)),
      .inc_i  (count_en && zone == KIW'(g)),
      .cnt_o  (cnt_w[g])
    );
  end

  // Hysteresis: between the thresholds the previously published state holds.
  assign cur     = cnt_w[k_q];
  assign cur_bit = (cur >= T_ON) ? 1'b1 : (cur < T_OFF) ? 1'b0 : keys_q[k_q];

  always_comb begin
    nxt_d      = nxt_q;
    nxt_d[k_q] = cur_bit;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ACCUM;
      k_q     <= '0;
      nxt_q   <= '0;
      keys_q  <= '0;
      vld_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      chg_q <= 1'b0;
      case (state_q)
        ACCUM: if (frame_end) begin
          state_q <= EVAL;
          k_q     <= '0;
        end
        EVAL: begin
          nxt_q <= nxt_d;
          if (last_k) begin
            keys_q  <= nxt_d;
            vld_q   <= 1'b1;
            chg_q   <= (nxt_d != keys_q);
            state_q <= ACCUM;
            k_q     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign keys_out         = keys_q;
  assign keys_valid_out   = vld_q;
  assign keys_changed_out = chg_q;
endmodule
